// File: rtl/rf_scoreboard_pkg.sv
// Shared constants for the decode-stage register file and hazard scoreboard:
// default widths and latencies, Tnew/Tuse encodings, and well-known register indices.
package rf_scoreboard_pkg;

  localparam int TNEW_W_DEF  = 2;
  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;
  localparam int RA_IDX      = 31;

  typedef enum logic [TNEW_W_DEF-1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2
  } tnew_e;

  // The issue cycle is the first busy cycle, so the counter holds the remaining LAT-1.
  function automatic int md_load(input logic is_div, input int mul_lat, input int div_lat);
    return is_div ? div_lat - 1 : mul_lat - 1;
  endfunction

endpackage

// File: rtl/sb_entry.sv
// One scoreboard slot: outstanding-writer count and Tnew countdown for a
// single architectural register.
module sb_entry
  import rf_scoreboard_pkg::*;
#(
  parameter  int TNEW_W = TNEW_W_DEF,
  parameter  int DEPTH  = 4,
  localparam int OUT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue,
  input  logic              retire,
  input  logic [TNEW_W-1:0] issue_tnew,
  output logic              pending,
  output logic [TNEW_W-1:0] tn
);

  logic [OUT_W-1:0] out_cnt;

  // NOTE: state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_cnt <= '0;
      tn      <= '0;
    end else begin
      if (issue)
        tn <= issue_tnew;
      else if (tn != '0)
        tn <= tn - 1'b1;

      if (issue && !retire)
        out_cnt <= out_cnt + 1'b1;
      else if (retire && !issue)
        out_cnt <= out_cnt - 1'b1;
    end
  end

  assign pending = (out_cnt != '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(issue && !retire && out_cnt == OUT_W'(DEPTH)));

  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(retire && !issue && out_cnt == '0));

endmodule

// File: rtl/rf_scoreboard.sv
// Decode-stage register file with per-register Tnew scoreboard and MD busy counter.
// Optional macro RF_INTERNAL_BYPASS_EN enables same-cycle write-through on reads.
module rf_scoreboard
  import rf_scoreboard_pkg::*;
#(
  parameter  int DATA_W  = 32,
  parameter  int NREG    = 32,
  parameter  int NRD     = 2,
  parameter  int TNEW_W  = TNEW_W_DEF,
  parameter  int DEPTH   = 4,
  parameter  int MUL_LAT = MUL_LAT_DEF,
  parameter  int DIV_LAT = DIV_LAT_DEF,
  localparam int AW      = $clog2(NREG),
  localparam int OUT_W   = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRD-1:0]        rd_en,
  input  logic [NRD*AW-1:0]     rd_addr,
  input  logic [NRD*TNEW_W-1:0] rd_tuse,
  output logic [NRD*DATA_W-1:0] rd_data,
  input  logic                  issue_valid,
  input  logic [AW-1:0]         issue_a3,
  input  logic [TNEW_W-1:0]     issue_tnew,
  input  logic                  issue_md,
  input  logic                  issue_div,
  output logic                  issue_fire,
  output logic                  stall,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  md_busy
);

  localparam int MD_MAX = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int MD_W   = $clog2(MD_MAX + 1);

  logic [DATA_W-1:0]            regs [NREG];
  logic [NREG-1:0]              pending;
  logic [NREG-1:0][TNEW_W-1:0]  tn_all;
  logic [NRD-1:0]               data_hz;
  logic [MD_W-1:0]              md_cnt;

  // NOTE: the array has few enough entries that an async clear is affordable and
  // gives a defined architectural state; $0 is never written so it stays zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else if (wr_en && wr_addr != '0) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign pending[0] = 1'b0;
  assign tn_all[0]  = TNEW_W'(T0);

  for (genvar r = 1; r < NREG; r++) begin : g_sb
    sb_entry #(.TNEW_W(TNEW_W), .DEPTH(DEPTH)) u_entry (
      .clk       (clk),
      .reset     (reset),
      .issue     (issue_fire && issue_a3 == AW'(r)),
      .retire    (wr_en && wr_addr == AW'(r)),
      .issue_tnew(issue_tnew),
      .pending   (pending[r]),
      .tn        (tn_all[r])
    );
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]     a;
    logic [TNEW_W-1:0] tuse;
    logic [DATA_W-1:0] rdv;

    assign a    = rd_addr[i*AW +: AW];
    assign tuse = rd_tuse[i*TNEW_W +: TNEW_W];
`ifdef RF_INTERNAL_BYPASS_EN
    assign rdv  = (wr_en && wr_addr == a && a != '0) ? wr_data : regs[a];
`else
    assign rdv  = regs[a];
`endif
    assign rd_data[i*DATA_W +: DATA_W] = rdv;
    assign data_hz[i] = rd_en[i] && (a != '0) && pending[a] && (tn_all[a] > tuse);
  end

  assign md_busy    = (md_cnt != '0);
  assign stall      = issue_valid && ((|data_hz) || (issue_md && md_busy));
  assign issue_fire = issue_valid && !stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      md_cnt <= '0;
    else if (issue_fire && issue_md)
      md_cnt <= MD_W'(md_load(issue_div, MUL_LAT, DIV_LAT));
    else if (md_cnt != '0)
      md_cnt <= md_cnt - 1'b1;
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench for rf_scoreboard: a register/scoreboard model checked every
// cycle, plus literal expectations for the load-use, MD and bypass scenarios.
module tb_rf_scoreboard;
  import rf_scoreboard_pkg::*;

  localparam int DATA_W = 32;
  localparam int NREG   = 32;
  localparam int NRD    = 2;
  localparam int TW     = 2;
  localparam int AW     = 5;

  logic                  clk   = 1'b0;
  logic                  reset = 1'b1;
  logic [NRD-1:0]        rd_en;
  logic [NRD*AW-1:0]     rd_addr;
  logic [NRD*TW-1:0]     rd_tuse;
  logic [NRD*DATA_W-1:0] rd_data;
  logic                  issue_valid;
  logic [AW-1:0]         issue_a3;
  logic [TW-1:0]         issue_tnew;
  logic                  issue_md;
  logic                  issue_div;
  logic                  issue_fire;
  logic                  stall;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  md_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rf_scoreboard dut (
    .clk        (clk),
    .reset      (reset),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_tuse    (rd_tuse),
    .rd_data    (rd_data),
    .issue_valid(issue_valid),
    .issue_a3   (issue_a3),
    .issue_tnew (issue_tnew),
    .issue_md   (issue_md),
    .issue_div  (issue_div),
    .issue_fire (issue_fire),
    .stall      (stall),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .md_busy    (md_busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: outstanding writers, cycles until forwardable, register values, MD cycles left.
  int                m_out [NREG];
  int                m_tn  [NREG];
  logic [DATA_W-1:0] m_reg [NREG];
  int                m_md;

  function automatic logic exp_stall();
    logic hz;
    hz = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      int a;
      a = int'(rd_addr[i*AW +: AW]);
      if (rd_en[i] && a != 0 && m_out[a] > 0 && m_tn[a] > int'(rd_tuse[i*TW +: TW])) hz = 1'b1;
    end
    if (issue_md && m_md > 0) hz = 1'b1;
    return issue_valid && hz;
  endfunction

  function automatic logic [DATA_W-1:0] exp_rd(input int i);
    int a;
    a = int'(rd_addr[i*AW +: AW]);
    if (a == 0) return '0;
`ifdef RF_INTERNAL_BYPASS_EN
    if (wr_en && int'(wr_addr) == a) return wr_data;
`endif
    return m_reg[a];
  endfunction

  always @(posedge clk or posedge reset) begin : model_upd
    logic fire;
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        m_out[r] = 0;
        m_tn[r]  = 0;
        m_reg[r] = '0;
      end
      m_md = 0;
    end else begin
      fire = issue_valid && !exp_stall();
      for (int r = 1; r < NREG; r++) begin
        if (fire && int'(issue_a3) == r) begin
          m_tn[r] = int'(issue_tnew);
          m_out[r]++;
        end else if (m_tn[r] > 0) begin
          m_tn[r]--;
        end
        if (wr_en && int'(wr_addr) == r) m_out[r]--;
      end
      if (wr_en && wr_addr != '0) m_reg[wr_addr] = wr_data;
      if (fire && issue_md) m_md = issue_div ? DIV_LAT_DEF - 1 : MUL_LAT_DEF - 1;
      else if (m_md > 0) m_md--;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("stall", stall, exp_stall());
      check("issue_fire", issue_fire, issue_valid && !exp_stall());
      check("md_busy", md_busy, m_md > 0);
      for (int i = 0; i < NRD; i++)
        check($sformatf("rd_data%0d", i), rd_data[i*DATA_W +: DATA_W], exp_rd(i));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en = '0; rd_addr = '0; rd_tuse = '0;
    issue_valid = 1'b0; issue_a3 = '0; issue_tnew = '0; issue_md = 1'b0; issue_div = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic rd(input int p, input int a, input int tuse);
    rd_en[p] = 1'b1;
    rd_addr[p*AW +: AW] = AW'(a);
    rd_tuse[p*TW +: TW] = TW'(tuse);
  endtask

  task automatic iss(input int a3, input int tnew, input logic md, input logic dv);
    issue_valid = 1'b1; issue_a3 = AW'(a3); issue_tnew = TW'(tnew);
    issue_md = md; issue_div = dv;
  endtask

  task automatic wb(input int a, input logic [DATA_W-1:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
  endtask

  task automatic count_stall(input string name, input int want);
    int n;
    n = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
      tick();
    end
    check(name, n, want);
  endtask

  task automatic wait_md_idle();
    for (int k = 0; k < 32; k++) begin
      if (md_busy === 1'b0) break;
      tick();
    end
    check("md_idle", md_busy, 0);
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    rd(0, 5, 0); rd(1, 5, 0); iss(0, 0, 0, 0);
    @(negedge clk);
    check("reset_rd0", rd_data[31:0], 0);
    check("reset_rd1", rd_data[63:32], 0);
    check("reset_stall", stall, 0);
    check("reset_md_busy", md_busy, 0);
    tick(); idle();

    // Load-use on $8
    iss(8, T2, 0, 0); tick(); idle();
    iss(0, 0, 0, 0); rd(0, 8, 0);
    count_stall("loaduse_tuse0", 2);
    tick(); idle();
    iss(8, T2, 0, 0); tick(); idle();
    iss(0, 0, 0, 0); rd(0, 8, 1);
    count_stall("loaduse_tuse1", 1);
    tick(); idle();

    // Two writers to $9: pending survives the first retire, drops on the second
    iss(9, 1, 0, 0); tick();
    iss(9, 3, 0, 0); tick(); idle();
    iss(0, 0, 0, 0); rd(0, 9, 0); wb(9, 32'h0000_0099);
    @(negedge clk); check("b2b_two_out", stall, 1);
    tick();
    @(negedge clk); check("b2b_one_out", stall, 1);
    tick(); wr_en = 1'b0;
    @(negedge clk); check("b2b_none_out", stall, 0);
    tick(); idle();

    // Same-cycle issue and retire on $10
    iss(10, 1, 0, 0); tick();
    iss(10, 3, 0, 0); wb(10, 32'h0000_0010); tick(); idle();
    iss(0, 0, 0, 0); rd(0, 10, 0);
    @(negedge clk); check("same_cycle_tn_reload", stall, 1);
    tick(); wb(10, 32'h0000_1010);
    tick(); wr_en = 1'b0;
    @(negedge clk); check("same_cycle_out_kept", stall, 0);
    tick(); idle();

    // MD busy: mult then div
    iss(0, 0, 1, 0); tick();
    iss(0, 0, 1, 0);
    count_stall("mul_stall", MUL_LAT_DEF - 1);
    tick(); idle();
    wait_md_idle();
    iss(0, 0, 1, 1); tick();
    iss(0, 0, 1, 0);
    count_stall("div_stall", DIV_LAT_DEF - 1);
    tick(); idle();
    wait_md_idle();

    // Reset during a divide
    iss(0, 0, 1, 1); tick();
    iss(0, 0, 1, 0);
    @(negedge clk); check("pre_reset_stall", stall, 1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_stall", stall, 0);
    check("async_reset_md_busy", md_busy, 0);
    tick(); reset = 1'b0; idle();
    tick();

    // Same-cycle write/read of $3, writes to $0, and $ra
    iss(3, T0, 0, 0); tick(); idle();
    wb(3, 32'h1111_1111); tick(); idle();
    iss(3, T0, 0, 0); tick(); idle();
    wb(3, 32'hDEAD_BEEF); rd(0, 3, 0);
    @(negedge clk);
`ifdef RF_INTERNAL_BYPASS_EN
    check("bypass_rd", rd_data[31:0], 32'hDEAD_BEEF);
`else
    check("bypass_rd", rd_data[31:0], 32'h1111_1111);
`endif
    tick(); idle(); rd(0, 3, 0);
    @(negedge clk); check("after_write_rd", rd_data[31:0], 32'hDEAD_BEEF);
    tick(); idle();
    wb(0, 32'h1234_5678); rd(1, 0, 0);
    @(negedge clk); check("r0_same_cycle", rd_data[63:32], 0);
    tick(); idle(); rd(1, 0, 0);
    @(negedge clk); check("r0_after", rd_data[63:32], 0);
    tick(); idle();
    iss(RA_IDX, T2, 0, 0); tick(); idle();
    wb(RA_IDX, 32'h0BAD_F00D); tick(); idle();
    rd(1, RA_IDX, 0); iss(0, 0, 0, 0);
    @(negedge clk);
    check("ra_rd", rd_data[63:32], 32'h0BAD_F00D);
    check("ra_no_stall", stall, 0);
    tick(); idle();
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
